cpu_dmem_responder: RTL and testbench



---
 rtl/cpu_dmem_responder_if.sv | 52 +++++
 rtl/cpu_dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_cpu_dmem_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_dmem_responder_if
//  Description : CPU load/store request bus between the CPU (master) and the
//                data-memory responder (slave). Single-word requests, with a
//                one-cycle Ack/Err completion and a Busy indication.
//                When DMEM_BYTE_WRITE_EN is defined, a 2-bit ByteEn lane
//                mask travels with each request.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_dmem_responder_if #(
   parameter int ADDR_W = 8
);
   // Request side, driven by the CPU
   logic              Req;
   logic              We;
   logic [ADDR_W-1:0] Addr;
   logic [15:0]       WData;
`ifdef DMEM_BYTE_WRITE_EN
   logic [1:0]        ByteEn;
`endif

   // Response side, driven by the responder
   logic [15:0]       RData;
   logic              Ack;
   logic              Err;
   logic              Busy;

`ifdef DMEM_BYTE_WRITE_EN
   modport master (
      output Req, We, Addr, WData, ByteEn,
      input  RData, Ack, Err, Busy
   );

   modport slave (
      input  Req, We, Addr, WData, ByteEn,
      output RData, Ack, Err, Busy
   );
`else
   modport master (
      output Req, We, Addr, WData,
      input  RData, Ack, Err, Busy
   );

   modport slave (
      input  Req, We, Addr, WData,
      output RData, Ack, Err, Busy
   );
`endif

endinterface : cpu_dmem_responder_if
`default_nettype wire

// File: rtl/cpu_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_dmem_responder
//  Description : Data-memory responder for the 16-bit CPU. Latches a single
//                read/write request, waits WAIT_CYCLES wait states, performs
//                the access against on-chip storage and returns a one-cycle
//                Ack with read data or an out-of-range Err flag.
//  Options     : DMEM_BYTE_WRITE_EN - adds per-byte write enables (ByteEn).
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_dmem_responder #(
   parameter int ADDR_W      = 8,    // word-address width
   parameter int DEPTH       = 256,  // implemented words, 1..2**ADDR_W
   parameter int WAIT_CYCLES = 2     // wait states, 0..15
) (
   input wire                  Clk,
   input wire                  Rst_n,
   cpu_dmem_responder_if.slave bus
);

   // Index width into the storage array; addresses at or above DEPTH never
   // reach the array, so only the low IDX_W bits are needed to index it.
   localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]        WAIT_L  = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;

   // Latched request
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [15:0]       wdata_q, wdata_d;
`ifdef DMEM_BYTE_WRITE_EN
   logic [1:0]        byte_en_q, byte_en_d;
`endif

   // Registered response outputs
   logic [15:0]       rdata_q, rdata_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;

   // Storage (not reset) and its access path
   logic [15:0]       mem_q [DEPTH];
   logic [IDX_W-1:0]  mem_idx;
   logic [15:0]       mem_rdata;
   logic [1:0]        lane_we;     // per-byte write strobes for this cycle
   logic              in_range;

   assign mem_idx   = addr_q[IDX_W-1:0];
   assign mem_rdata = mem_q[mem_idx];
   assign in_range  = ({1'b0, addr_q} < DEPTH_L);

   // Next-state, request latching and response generation
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
`ifdef DMEM_BYTE_WRITE_EN
      byte_en_d = byte_en_q;
`endif
      rdata_d   = rdata_q;
      ack_d     = 1'b0;       // Ack is a single-cycle pulse
      err_d     = 1'b0;       // Err only accompanies Ack
      busy_d    = busy_q;
      lane_we   = 2'b00;

      case (state_q)
         ST_IDLE: begin
            if (bus.Req) begin
               addr_d    = bus.Addr;
               we_d      = bus.We;
               wdata_d   = bus.WData;
`ifdef DMEM_BYTE_WRITE_EN
               byte_en_d = bus.ByteEn;
`endif
               busy_d    = 1'b1;
               cnt_d     = WAIT_L;
               state_d   = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            end
         end

         ST_WAIT: begin
            // Leaving on a count of 1 puts RESP exactly WAIT_CYCLES edges
            // after acceptance; the <= also guards against a stray zero.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            if (in_range) begin
               if (we_q) begin
`ifdef DMEM_BYTE_WRITE_EN
                  lane_we = byte_en_q;
`else
                  lane_we = 2'b11;
`endif
               end else begin
                  rdata_d = mem_rdata;
               end
            end else begin
               rdata_d = 16'h0000;
               err_d   = 1'b1;
            end
            ack_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Control and response registers; reset aborts any transaction in flight
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= 16'h0000;
`ifdef DMEM_BYTE_WRITE_EN
         byte_en_q <= 2'b00;
`endif
         rdata_q   <= 16'h0000;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
`ifdef DMEM_BYTE_WRITE_EN
         byte_en_q <= byte_en_d;
`endif
         rdata_q   <= rdata_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   // Storage write port, one strobe per byte lane; contents survive reset
   always_ff @(posedge Clk) begin
      if (lane_we[0]) begin
         mem_q[mem_idx][7:0] <= wdata_q[7:0];
      end
      if (lane_we[1]) begin
         mem_q[mem_idx][15:8] <= wdata_q[15:8];
      end
   end

   assign bus.RData = rdata_q;
   assign bus.Ack   = ack_q;
   assign bus.Err   = err_q;
   assign bus.Busy  = busy_q;

endmodule : cpu_dmem_responder
`default_nettype wire

// File: tb/tb_cpu_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_dmem_responder
//  Description : Self-checking bench for cpu_dmem_responder. DUT A uses
//                DEPTH=200 / WAIT_CYCLES=2, DUT B uses DEPTH=256 /
//                WAIT_CYCLES=0. A vector table drives DUT A; hand-written
//                sequences cover reset, busy-ignore, mid-transaction reset,
//                zero-wait throughput and (when DMEM_BYTE_WRITE_EN is
//                defined) byte-lane writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_dmem_responder;

   logic clk;
   logic rst_n;

   cpu_dmem_responder_if #(.ADDR_W(8)) bus_a ();
   cpu_dmem_responder_if #(.ADDR_W(8)) bus_b ();

   cpu_dmem_responder #(.ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) u_dut_a (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   cpu_dmem_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_dut_b (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Selects which DUT the helper tasks drive and observe (0 = A, 1 = B)
   int         cur = 0;
   logic [1:0] be  = 2'b11;

   logic        w_ack, w_err, w_busy;
   logic [15:0] w_rdata;
   assign w_ack   = (cur == 0) ? bus_a.Ack   : bus_b.Ack;
   assign w_err   = (cur == 0) ? bus_a.Err   : bus_b.Err;
   assign w_busy  = (cur == 0) ? bus_a.Busy  : bus_b.Busy;
   assign w_rdata = (cur == 0) ? bus_a.RData : bus_b.RData;

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic req, input logic we, input logic [7:0] addr,
                        input logic [15:0] wdata);
      if (cur == 0) begin
         bus_a.Req = req; bus_a.We = we; bus_a.Addr = addr; bus_a.WData = wdata;
`ifdef DMEM_BYTE_WRITE_EN
         bus_a.ByteEn = be;
`endif
      end else begin
         bus_b.Req = req; bus_b.We = we; bus_b.Addr = addr; bus_b.WData = wdata;
`ifdef DMEM_BYTE_WRITE_EN
         bus_b.ByteEn = be;
`endif
      end
   endtask

   // One request; returns the response sampled in the Ack cycle
   task automatic txn(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                      input int exp_lat, input string tag,
                      output logic [15:0] rd, output logic err);
      int lat;
      @(negedge clk);
      drive(1'b1, we, addr, wdata);
      @(posedge clk);
      #1;
      drive(1'b0, we, addr, wdata);
      check({tag, "_busy_e0"}, {31'd0, w_busy}, 32'd1);
      check({tag, "_ackerr_e0"}, {30'd0, w_ack, w_err}, 32'd0);
      lat = 0;
      while (!w_ack && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_busy_ack"}, {31'd0, w_busy}, 32'd0);
      rd  = w_rdata;
      err = w_err;
   endtask

   logic [15:0] rd;
   logic        err;
   int          acks;
   logic        prev_ack;

   initial begin
      vecs[0]  = '{1'b1, 8'h05, 16'hBEEF, 16'h0000, 1'b0};
      vecs[1]  = '{1'b0, 8'h05, 16'h0000, 16'hBEEF, 1'b0};
      vecs[2]  = '{1'b1, 8'h0A, 16'h1357, 16'hBEEF, 1'b0};
      vecs[3]  = '{1'b1, 8'd210, 16'hFFFF, 16'h0000, 1'b1};
      vecs[4]  = '{1'b0, 8'h0A, 16'h0000, 16'h1357, 1'b0};
      vecs[5]  = '{1'b0, 8'd210, 16'h0000, 16'h0000, 1'b1};
      vecs[6]  = '{1'b1, 8'd199, 16'hCAFE, 16'h0000, 1'b0};
      vecs[7]  = '{1'b0, 8'd199, 16'h0000, 16'hCAFE, 1'b0};
      vecs[8]  = '{1'b1, 8'd200, 16'h1111, 16'h0000, 1'b1};
      vecs[9]  = '{1'b0, 8'd199, 16'h0000, 16'hCAFE, 1'b0};
      vecs[10] = '{1'b1, 8'h07, 16'h5555, 16'hCAFE, 1'b0};
      vecs[11] = '{1'b0, 8'h07, 16'h0000, 16'h5555, 1'b0};
      vecs[12] = '{1'b1, 8'h05, 16'h0001, 16'h5555, 1'b0};
      vecs[13] = '{1'b0, 8'h05, 16'h0000, 16'h0001, 1'b0};

      // Reset with Req asserted on both DUTs
      rst_n = 1'b0;
      cur = 1; drive(1'b1, 1'b1, 8'h03, 16'h9999);
      cur = 0; drive(1'b1, 1'b1, 8'h03, 16'h9999);
      repeat (3) @(posedge clk);
      @(negedge clk);
      cur = 1; drive(1'b0, 1'b0, 8'h00, 16'h0000);
      cur = 0; drive(1'b0, 1'b0, 8'h00, 16'h0000);
      rst_n = 1'b1;
      #1;
      check("rst_a_outputs", {bus_a.RData, 13'd0, bus_a.Ack, bus_a.Err, bus_a.Busy}, 32'd0);
      check("rst_b_outputs", {bus_b.RData, 13'd0, bus_b.Ack, bus_b.Err, bus_b.Busy}, 32'd0);
      acks = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus_a.Ack || bus_a.Busy || bus_b.Ack || bus_b.Busy) acks++;
      end
      check("rst_req_ignored", acks, 0);

      // Table-driven transactions on DUT A
      cur = 0;
      for (int i = 0; i < 14; i++) begin
         txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, 3, $sformatf("vec%0d", i), rd, err);
         check($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp_rd});
         check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      end
      // Err must clear on the edge after its Ack
      txn(1'b0, 8'd250, 16'h0000, 3, "err_last", rd, err);
      check("err_last_err", {31'd0, err}, 32'd1);
      @(posedge clk); #1;
      check("err_clears", {30'd0, bus_a.Ack, bus_a.Err}, 32'd0);

      // Requests and input changes while busy are ignored
      txn(1'b1, 8'h21, 16'h3333, 3, "pre21", rd, err);
      @(negedge clk);
      drive(1'b1, 1'b1, 8'h20, 16'h1111);
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 8'h21, 16'h2222);
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (bus_a.Ack) acks++;
      end
      drive(1'b0, 1'b0, 8'h00, 16'h0000);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus_a.Ack) acks++;
      end
      check("busy_one_ack", acks, 1);
      txn(1'b0, 8'h20, 16'h0000, 3, "rd20", rd, err);
      check("busy_orig_data", {16'd0, rd}, 32'h1111);
      txn(1'b0, 8'h21, 16'h0000, 3, "rd21", rd, err);
      check("busy_other_untouched", {16'd0, rd}, 32'h3333);

      // Reset during WAIT of a write aborts it
      @(negedge clk);
      drive(1'b1, 1'b1, 8'h07, 16'hAAAA);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'h00, 16'h0000);
      check("midrst_busy_before", {31'd0, bus_a.Busy}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_async_clear", {bus_a.RData, 13'd0, bus_a.Ack, bus_a.Err, bus_a.Busy}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus_a.Ack) acks++;
      end
      check("midrst_no_ack", acks, 0);
      txn(1'b0, 8'h07, 16'h0000, 3, "midrst_rd", rd, err);
      check("midrst_mem_kept", {16'd0, rd}, 32'h5555);

`ifdef DMEM_BYTE_WRITE_EN
      // Byte-lane writes over 16'h5555
      be = 2'b01;
      txn(1'b1, 8'h07, 16'hAB12, 3, "be01_wr", rd, err);
      be = 2'b11;
      txn(1'b0, 8'h07, 16'h0000, 3, "be01_rd", rd, err);
      check("be01_data", {16'd0, rd}, 32'h5512);
      be = 2'b00;
      txn(1'b1, 8'h07, 16'hFFFF, 3, "be00_wr", rd, err);
      check("be00_err", {31'd0, err}, 32'd0);
      txn(1'b0, 8'h07, 16'h0000, 3, "be00_rd", rd, err);
      check("be00_data", {16'd0, rd}, 32'h5512);
      be = 2'b10;
      txn(1'b1, 8'h07, 16'hC3FF, 3, "be10_wr", rd, err);
      be = 2'b11;
      txn(1'b0, 8'h07, 16'h0000, 3, "be10_rd", rd, err);
      check("be10_data", {16'd0, rd}, 32'hC312);
`endif

      // Zero wait states on DUT B
      cur = 1;
      txn(1'b1, 8'h00, 16'h1234, 1, "w0_wr", rd, err);
      check("w0_wr_rdata_hold", {16'd0, rd}, 32'h0000);
      txn(1'b0, 8'h00, 16'h0000, 1, "w0_rd", rd, err);
      check("w0_rd_data", {16'd0, rd}, 32'h1234);
      txn(1'b1, 8'hFF, 16'h0F0F, 1, "w0_top_wr", rd, err);
      check("w0_top_err", {31'd0, err}, 32'd0);

      // Req held high: one access every two cycles
      @(negedge clk);
      drive(1'b1, 1'b0, 8'h00, 16'h0000);
      acks = 0;
      prev_ack = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus_b.Ack) begin
            acks++;
            check($sformatf("w0_stream_rd%0d", i), {16'd0, bus_b.RData}, 32'h1234);
            check($sformatf("w0_stream_gap%0d", i), {31'd0, prev_ack}, 32'd0);
         end
         prev_ack = bus_b.Ack;
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 16'h0000);
      check("w0_stream_acks", acks, 6);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_cpu_dmem_responder
`default_nettype wire
